// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider producing per-channel
// tick strobes and square waves, with divisor changes deferred to period boundaries.
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int DIV_W = 16,
  parameter int DEF_DIV = 5208,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [DIV_W-1:0]    WR_DIV,
  input  logic [CHANNELS-1:0] CH_EN,
  input  logic                SYNC,
  output logic [CHANNELS-1:0] TICK,
  output logic [CHANNELS-1:0] CLK_OUT,
  output logic [CHANNELS-1:0] PEND
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pdiv_q, pdiv_d, n_cur, n_new;
    logic pv_q, pv_d, tick_q, tick_d, clk_q, clk_d, en, wr, wrap, apply;
    always_comb begin
      en = CH_EN[c];
      wr = WR_EN && (WR_CH == CH_W'(c));
      n_cur = (act_q < TWO) ? TWO : act_q;
      wrap = cnt_q == n_cur - ONE;
      // pending value is consumed before any same-edge write re-arms it
      apply = en && pv_q && (SYNC || wrap);
      act_d = apply ? pdiv_q : (wr && !en) ? WR_DIV : act_q;
      pdiv_d = (wr && en) ? WR_DIV : pdiv_q;
      pv_d = wr ? en : apply ? 1'b0 : pv_q;
      n_new = (act_d < TWO) ? TWO : act_d;
      cnt_d = (!en || SYNC || wrap) ? '0 : cnt_q + ONE;
      tick_d = en && !SYNC && wrap;
      clk_d = en && (SYNC || (cnt_d < (n_new >> 1)));
    end
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q <= '0;
        act_q <= RST_DIV;
        pdiv_q <= RST_DIV;
        pv_q <= 1'b0;
        tick_q <= 1'b0;
        clk_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
        pdiv_q <= pdiv_d;
        pv_q <= pv_d;
        tick_q <= tick_d;
        clk_q <= clk_d;
      end
    end
    assign TICK[c] = tick_q;
    assign CLK_OUT[c] = clk_q;
    assign PEND[c] = pv_q;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed self-checking bench for clk_div_multi (5 channels, reset divisor 4).
module tb_clk_div_multi;
  localparam int CH = 5, DW = 16, CW = 3;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, sync = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [DW-1:0] wr_div = '0;
  logic [CH-1:0] ch_en = '0, tick, clk_out, pend;
  int checks = 0, errors = 0;
  int n_exp [4];

  clk_div_multi #(.CHANNELS(CH), .DIV_W(DW), .DEF_DIV(4)) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_DIV(wr_div),
    .CH_EN(ch_en), .SYNC(sync), .TICK(tick), .CLK_OUT(clk_out), .PEND(pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1;
    wr_ch = CW'(ch);
    wr_div = DW'(d);
  endtask

  function automatic logic [3:0] tk(input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (k % n_exp[i]) == 0;
    return r;
  endfunction

  function automatic logic [3:0] cl(input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (k % n_exp[i]) < (n_exp[i] >> 1);
    return r;
  endfunction

  task automatic run(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      step();
      chk("model_tick", tick, {1'b0, tk(k)});
      chk("model_clk", clk_out, {1'b0, cl(k)});
    end
  endtask

  initial begin
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_clk", clk_out, 0);
    chk("rst_pend", pend, 0);
    repeat (3) step();
    chk("rst_hold", {tick, clk_out, pend}, 0);
    rst = 1'b0;
    ch_en = 5'b00001;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("p1_tick", tick, {4'b0, k % 4 == 0});
      chk("p1_clk", clk_out, {4'b0, (k % 4) < 2});
    end
    ch_en = 5'b00010;
    step();
    chk("p2_ch0_off", {tick[0], clk_out[0]}, 0);
    step();
    wr(1, 6);
    step();
    wr_en = 1'b0;
    chk("p2_pend", pend, 5'b00010);
    step();
    chk("p2_wrap_tick", tick, 5'b00010);
    chk("p2_wrap_pend", pend, 0);
    chk("p2_wrap_clk", clk_out, 5'b00010);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("p2_tick", tick, {3'b0, k % 6 == 0, 1'b0});
      chk("p2_clk", clk_out, {3'b0, (k % 6) < 3, 1'b0});
    end
    ch_en = '0;
    wr(2, 0);
    step();
    wr_en = 1'b0;
    chk("p3_pend0", pend, 0);
    chk("p3_off", {tick, clk_out}, 0);
    ch_en = 5'b00100;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("p3_div0_tick", tick, {2'b0, k % 2 == 0, 2'b0});
      chk("p3_div0_clk", clk_out, {2'b0, k % 2 == 0, 2'b0});
    end
    ch_en = '0;
    wr(2, 1);
    step();
    wr_en = 1'b0;
    chk("p3_pend1", pend, 0);
    ch_en = 5'b00100;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("p3_div1_tick", tick, {2'b0, k % 2 == 0, 2'b0});
      chk("p3_div1_clk", clk_out, {2'b0, k % 2 == 0, 2'b0});
    end
    ch_en = '0;
    wr(2, 5);
    step();
    wr_en = 1'b0;
    ch_en = 5'b00100;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("p3_div5_tick", tick, {2'b0, k % 5 == 0, 2'b0});
      chk("p3_div5_clk", clk_out, {2'b0, (k % 5) < 2, 2'b0});
    end
    ch_en = '0;
    for (int i = 0; i < 4; i++) begin
      wr(i, 4 + i);
      step();
    end
    wr_en = 1'b0;
    chk("p4_pend", pend, 0);
    n_exp = '{4, 5, 6, 7};
    ch_en = 5'b00001;
    repeat (3) step();
    ch_en = 5'b00011;
    repeat (2) step();
    ch_en = 5'b01111;
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_tick", tick, 0);
    chk("sync_clk", clk_out, 5'b01111);
    run(1, 8);
    wr(0, 3);
    step();
    wr_en = 1'b0;
    chk("p4b_pend", pend, 5'b00001);
    sync = 1'b1;
    wr(0, 8);
    step();
    sync = 1'b0;
    wr_en = 1'b0;
    chk("sync_wr_pend", pend, 5'b00001);
    chk("sync_wr_tick", tick, 0);
    chk("sync_wr_clk", clk_out, 5'b01111);
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("p4b_tick0", tick[0], k == 3 || k == 11);
      chk("p4b_pend0", pend[0], k < 3);
    end
    n_exp = '{8, 5, 6, 7};
    sync = 1'b1;
    wr(5, 9);
    step();
    sync = 1'b0;
    chk("oor5_pend", pend, 0);
    wr(7, 9);
    step();
    wr_en = 1'b0;
    chk("oor7_pend", pend, 0);
    chk("oor7_tick", tick, {1'b0, tk(1)});
    run(2, 10);
    sync = 1'b1;
    step();
    sync = 1'b0;
    wr(1, 8);
    step();
    wr(1, 10);
    step();
    wr_en = 1'b0;
    chk("p5_pend", pend, 5'b00010);
    for (int k = 3; k <= 15; k++) begin
      step();
      chk("p5_tick1", tick[1], k == 5 || k == 15);
      chk("p5_pend1", pend[1], k < 5);
    end
    wr(1, 12);
    step();
    wr_en = 1'b0;
    chk("p6_pend", pend, 5'b00010);
    #2 rst = 1'b1;
    #1;
    chk("p6_async_tick", tick, 0);
    chk("p6_async_clk", clk_out, 0);
    chk("p6_async_pend", pend, 0);
    step();
    #2 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("p6_tick1", tick[1], k % 4 == 0);
      chk("p6_pend", pend, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider; successor to the fixed single-output divider.
- Each channel produces a one-cycle TICK strobe every N input clocks and a registered square wave.
- N is runtime-writable per channel. New values take effect glitch-free at the period boundary.
- Feeds UART baud generation and BLDC PWM/commutation timing from one system clock.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
DIV_W, 16, divisor and counter width in bits
DEF_DIV, 5208, reset divisor for all channels (50 MHz / 9600 baud)
CH_W, max(1,clog2(CHANNELS)), channel-select width (localparam)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
WR_EN  in  1  divisor write strobe, one cycle
WR_CH  in  CH_W  channel index for write
WR_DIV  in  DIV_W  new divisor value
CH_EN  in  CHANNELS  per-channel run enable
SYNC  in  1  phase-align all enabled channels
TICK  out  CHANNELS  one-cycle strobe per period, per channel
CLK_OUT  out  CHANNELS  divided square wave, per channel
PEND  out  CHANNELS  divisor write pending, per channel

Behaviour:
- Clocking and reset: one clock domain, CLK. RST is asynchronous, active-high.
- Reset values:
  - cnt=0 and act_div=DEF_DIV for all channels.
  - pend_div=DEF_DIV and pend_valid=0.
  - TICK=0, CLK_OUT=0, PEND=0.
- Effective ratio: N = max(act_div, 2). Divisor values 0 and 1 are clamped to 2. Comparisons use DIV_W-bit unsigned arithmetic.
- Enabled channel (CH_EN[i]=1, SYNC=0), each edge:
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
  - TICK[i] <= (cnt==N-1). It is high for exactly the cycle after the wrap, i.e. one cycle in every N.
  - CLK_OUT[i] <= (cnt_next < N>>1). High for N>>1 cycles and low for N-(N>>1) cycles; odd N gives the shorter high phase.
- Disabled channel:
  - cnt held at 0; TICK[i]=0 and CLK_OUT[i]=0 from the next edge.
  - Re-enable restarts from cnt=0. The first TICK occurs N edges after the first enabled edge.
- Divisor write (WR_EN=1, WR_CH<CHANNELS):
  - If channel enabled: pend_div <= WR_DIV and pend_valid <= 1. PEND[i] rises on the next edge.
  - If channel disabled: act_div <= WR_DIV directly; pend_valid stays 0.
  - WR_CH >= CHANNELS: write ignored, no state change.
- Pending apply: on the wrap edge (cnt==N-1 → 0) with pend_valid=1:
  - act_div <= pend_div and pend_valid <= 0.
  - The new N governs the period starting at cnt=0. The TICK for the wrap is still issued. CLK_OUT for that edge uses the new N.
- Multiple writes before a wrap: last write wins.
- Write coinciding with a wrap edge: the pending value that existed before the edge is applied. The new write becomes pending for the following wrap.
- SYNC=1 (highest priority after RST), enabled channels:
  - cnt <= 0; any pending divisor is applied immediately; pend_valid <= 0.
  - TICK <= 0; CLK_OUT <= 1.
- SYNC=1, disabled channels: SYNC has no effect.
- SYNC and WR_EN on the same edge: SYNC applies the old pending value. The write then becomes pending.
- Channels are fully independent apart from SYNC. No cross-channel combinational paths.
- RST asserted mid-period: all state returns to reset values immediately. Counting resumes at cnt=0 after RST deasserts.
- All outputs are driven directly from flops.

Test Plan:
- DEF_DIV=4, RST 3 cycles, CH_EN=0001 → TICK[0] pulses once every 4 cycles, first pulse 4 edges after enable. CLK_OUT[0] pattern is 1,1,0,0 repeating. Other channels stay 0.
- Enabled ch1 at N=4, write WR_DIV=6 mid-period → PEND[1]=1 until the next wrap. The current period completes at 4. Later periods are 6 cycles with CLK_OUT 3 high / 3 low. PEND[1] clears on the wrap edge.
- WR_DIV=0, WR_DIV=1, then WR_DIV=5 to disabled ch2, then enable → 0 and 1 each behave as N=2 (TICK every cycle pair). 5 gives CLK_OUT 2 high / 3 low.
- Channels 0..3 running at N=4,5,6,7 with arbitrary phase; pulse SYNC → all cnt=0 and all CLK_OUT=1 on the next edge. Next TICKs occur at 4/5/6/7 cycles after SYNC.
- Write to WR_CH=5 with CHANNELS=4 → no PEND change and periods unchanged. Two writes (8 then 10) before a wrap → period becomes 10.
- RST asserted mid-period with a divisor pending → TICK, CLK_OUT and PEND go to 0 asynchronously. After release, the period reverts to DEF_DIV and the pending value is lost.
